// File: rtl/sync_delay_cfg.sv
// sync_delay_cfg -- configurable hsync/vsync delay generator.
//
// Purpose:
//   Delays a line-start trigger by H_DLY clock cycles and then emits a pulse
//   PULSE_W cycles wide. In MODE 0, vsync has its own identical delay channel.
//   In MODE 1, vsync arms a line counter, and vsync_dly is then asserted
//   together with the hsync_dly pulse that follows the V_LINES-th hsync.
//
// Ports:
//   clk        in   single rising-edge clock
//   rst        in   asynchronous active-high reset
//   hsync      in   line-start pulse
//   vsync      in   frame-start pulse
//   clr_err    in   synchronous clear of the sticky error flags
//   hsync_dly  out  delayed hsync pulse (registered)
//   vsync_dly  out  delayed vsync pulse (registered)
//   h_overrun  out  sticky: a horizontal trigger arrived while a delay was pending
//   v_overrun  out  sticky: vsync arrived while its channel or frame was pending
//   line_cnt   out  hsync_dly pulses since the last vsync_dly (saturating)
module sync_delay_cfg #(
  parameter int CNT_W   = 8,
  parameter int H_DLY   = 8'h32,
  parameter int PULSE_W = 1,
  parameter int MODE    = 1,
  parameter int V_LINES = 3,
  parameter int RETRIG  = 0,
  parameter int LINE_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              clr_err,
  output logic              hsync_dly,
  output logic              vsync_dly,
  output logic              h_overrun,
  output logic              v_overrun,
  output logic [LINE_W-1:0] line_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  H_DLY_C   = CNT_W'(H_DLY);
  localparam logic [CNT_W-1:0]  PULSE_C   = CNT_W'(PULSE_W);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]        V_LINES_C = 4'(V_LINES);
  localparam logic [LINE_W-1:0] LINE_ONE  = LINE_W'(1);
  localparam bit                RETRIG_EN = (RETRIG != 0);
  localparam bit                MODE1     = (MODE == 1);

  // Channel 0 is the horizontal delay; channel 1 is the MODE 0 vsync delay.
  logic             trig      [2];
  logic             busy_q    [2];
  logic             busy_d    [2];
  logic             out_q     [2];
  logic             out_d     [2];
  logic [CNT_W-1:0] dly_q     [2];
  logic [CNT_W-1:0] dly_d     [2];
  logic [CNT_W-1:0] pls_q     [2];
  logic [CNT_W-1:0] pls_d     [2];
  logic             pls_start [2];
  logic             ovr_evt   [2];

  state_t      state_q, state_d;
  logic [3:0]  vlines_q, vlines_d;
  logic        vdly_q, vdly_d;
  logic        fire_evt;
  logic        vsync_ovr_evt;
  logic        h_ovr_q, h_ovr_d;
  logic        v_ovr_q, v_ovr_d;
  logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
  logic        v_start;

  always_comb begin
    trig[0] = MODE1 ? (hsync | vsync) : hsync;
    trig[1] = MODE1 ? 1'b0 : vsync;
  end

  // Delay channels: count H_DLY cycles after the trigger, then hold the
  // output for PULSE_W cycles. busy covers the whole window up to and
  // including the last pulse cycle.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      busy_d[i]    = busy_q[i];
      out_d[i]     = out_q[i];
      dly_d[i]     = dly_q[i];
      pls_d[i]     = pls_q[i];
      pls_start[i] = 1'b0;
      ovr_evt[i]   = trig[i] & busy_q[i];
      if (trig[i] && (!busy_q[i] || RETRIG_EN)) begin
        // A reload also abandons any pulse already in progress.
        busy_d[i] = 1'b1;
        out_d[i]  = 1'b0;
        dly_d[i]  = H_DLY_C;
        pls_d[i]  = '0;
      end else if (busy_q[i]) begin
        if (out_q[i]) begin
          if (pls_q[i] == CNT_ONE) begin
            out_d[i]  = 1'b0;
            busy_d[i] = 1'b0;
            pls_d[i]  = '0;
          end else begin
            pls_d[i] = pls_q[i] - CNT_ONE;
          end
        end else if (dly_q[i] == CNT_ONE) begin
          out_d[i]     = 1'b1;
          pls_d[i]     = PULSE_C;
          pls_start[i] = 1'b1;
        end else begin
          dly_d[i] = dly_q[i] - CNT_ONE;
        end
      end
    end
  end

  // MODE 1 frame FSM. The line counter is inspected as registered, so an
  // hsync that brings it to zero only qualifies pulses starting later.
  always_comb begin
    state_d       = state_q;
    vlines_d      = vlines_q;
    vdly_d        = 1'b0;
    fire_evt      = 1'b0;
    vsync_ovr_evt = 1'b0;
    if (MODE1) begin
      case (state_q)
        ST_IDLE: begin
          if (vsync) begin
            state_d  = ST_ARMED;
            vlines_d = V_LINES_C;
          end
        end
        ST_ARMED: begin
          if (vsync) begin
            state_d       = ST_ARMED;
            vlines_d      = V_LINES_C;
            vsync_ovr_evt = 1'b1;
          end else begin
            if (vlines_q == 4'd0 && pls_start[0]) begin
              state_d  = ST_FIRE;
              vdly_d   = 1'b1;
              fire_evt = 1'b1;
            end
            if (hsync && vlines_q != 4'd0) begin
              vlines_d = vlines_q - 4'd1;
            end
          end
        end
        ST_FIRE: begin
          if (vsync) begin
            // Abandon this frame: vsync_dly drops immediately.
            state_d       = ST_ARMED;
            vlines_d      = V_LINES_C;
            vsync_ovr_evt = 1'b1;
          end else begin
            vdly_d = out_d[0];
            if (!out_d[0]) begin
              state_d = ST_IDLE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Sticky flags and line counter. A new event wins over clr_err.
  always_comb begin
    v_start    = MODE1 ? fire_evt : pls_start[1];
    h_ovr_d    = (h_ovr_q & ~clr_err) | ovr_evt[0];
    v_ovr_d    = (v_ovr_q & ~clr_err) | (MODE1 ? vsync_ovr_evt : ovr_evt[1]);
    line_cnt_d = line_cnt_q;
    if (v_start) begin
      line_cnt_d = '0;
    end else if (pls_start[0] && line_cnt_q != '1) begin
      line_cnt_d = line_cnt_q + LINE_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        busy_q[i] <= 1'b0;
        out_q[i]  <= 1'b0;
        dly_q[i]  <= '0;
        pls_q[i]  <= '0;
      end
      state_q    <= ST_IDLE;
      vlines_q   <= '0;
      vdly_q     <= 1'b0;
      h_ovr_q    <= 1'b0;
      v_ovr_q    <= 1'b0;
      line_cnt_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        busy_q[i] <= busy_d[i];
        out_q[i]  <= out_d[i];
        dly_q[i]  <= dly_d[i];
        pls_q[i]  <= pls_d[i];
      end
      state_q    <= state_d;
      vlines_q   <= vlines_d;
      vdly_q     <= vdly_d;
      h_ovr_q    <= h_ovr_d;
      v_ovr_q    <= v_ovr_d;
      line_cnt_q <= line_cnt_d;
    end
  end

  assign hsync_dly = out_q[0];
  assign vsync_dly = MODE1 ? vdly_q : out_q[1];
  assign h_overrun = h_ovr_q;
  assign v_overrun = v_ovr_q;
  assign line_cnt  = line_cnt_q;

endmodule
